// File: rtl/ib_lut_page_loader_pkg.sv
// Shared types and size helpers for the IB LUT page loader.
package ib_lut_page_loader_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  localparam int DEF_ENTRY_ADDR      = 4;
  localparam int DEF_MULTI_FRAME_NUM = 2;
  localparam int DEF_BANK_NUM        = 2;
  localparam int DEF_LUT_PORT_SIZE   = 2;
  localparam int DEF_ITER_ADDR       = 5;

  function automatic int frame_bits(input int mf);
    return $clog2(mf);
  endfunction

  function automatic int page_num(input int ea, input int mf);
    return 1 << (ea - $clog2(mf));
  endfunction

endpackage

// File: rtl/ib_lut_page_loader.sv
// Streams one iteration's LUT pages into the f3 function RAM write port.
// Define IB_LOAD_CHECKSUM_EN to add the running XOR checksum check.
module ib_lut_page_loader
  import ib_lut_page_loader_pkg::*;
#(
  parameter int ENTRY_ADDR      = DEF_ENTRY_ADDR,
  parameter int MULTI_FRAME_NUM = DEF_MULTI_FRAME_NUM,
  parameter int BANK_NUM        = DEF_BANK_NUM,
  parameter int LUT_PORT_SIZE   = DEF_LUT_PORT_SIZE,
  parameter int ITER_ADDR       = DEF_ITER_ADDR
) (
  input  logic                              write_clk,
  input  logic                              rst,
  input  logic                              load_req,
  input  logic [ITER_ADDR-1:0]              load_iter,
  input  logic                              frame_sel,
  input  logic                              load_abort,
  input  logic                              src_valid,
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] src_data,
  output logic                              src_ready,
  output logic [ITER_ADDR-1:0]              src_iter,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_3,
  output logic                              ib_ram_we,
  output logic                              load_busy,
`ifdef IB_LOAD_CHECKSUM_EN
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] exp_checksum,
  output logic                              checksum_err,
`endif
  output logic                              load_done
);

  localparam int FW = frame_bits(MULTI_FRAME_NUM);
  localparam int PW = ENTRY_ADDR - FW;
  localparam int DW = LUT_PORT_SIZE * BANK_NUM;
  localparam logic [PW-1:0] LAST =
    PW'(page_num(ENTRY_ADDR, MULTI_FRAME_NUM) - 1);

  state_e                state_q, state_d;
  logic [PW-1:0]         page_cnt_q, page_cnt_d;
  logic                  frame_q, frame_d;
  logic [ITER_ADDR-1:0]  iter_q, iter_d;
  logic [ENTRY_ADDR-1:0] addr_q, addr_d;
  logic [DW-1:0]         data_q, data_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
`ifdef IB_LOAD_CHECKSUM_EN
  logic [DW-1:0]         csum_q, csum_d;
  logic                  err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    page_cnt_d = page_cnt_q;
    frame_d    = frame_q;
    iter_d     = iter_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    src_ready  = 1'b0;
`ifdef IB_LOAD_CHECKSUM_EN
    csum_d     = csum_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d    = LOAD;
          page_cnt_d = '0;
          frame_d    = frame_sel;
          iter_d     = load_iter;
`ifdef IB_LOAD_CHECKSUM_EN
          csum_d     = '0;
          err_d      = 1'b0;
`endif
        end
      end
      LOAD: begin
        src_ready = ~load_abort;
        if (load_abort) begin
          state_d = IDLE;
        end else if (src_valid) begin
          we_d       = 1'b1;
          addr_d     = ENTRY_ADDR'({frame_q, page_cnt_q});
          data_d     = src_data;
          page_cnt_d = page_cnt_q + 1'b1;
`ifdef IB_LOAD_CHECKSUM_EN
          csum_d     = csum_q ^ src_data;
`endif
          if (page_cnt_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef IB_LOAD_CHECKSUM_EN
            err_d   = (csum_q ^ src_data) != exp_checksum;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge write_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      page_cnt_q <= '0;
      frame_q    <= 1'b0;
      iter_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
`ifdef IB_LOAD_CHECKSUM_EN
      csum_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      page_cnt_q <= page_cnt_d;
      frame_q    <= frame_d;
      iter_q     <= iter_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      done_q     <= done_d;
`ifdef IB_LOAD_CHECKSUM_EN
      csum_q     <= csum_d;
      err_q      <= err_d;
`endif
    end
  end

  assign src_iter         = iter_q;
  assign page_addr_ram    = addr_q;
  assign ram_write_data_3 = data_q;
  assign ib_ram_we        = we_q;
  assign load_busy        = (state_q == LOAD);
  assign load_done        = done_q;
`ifdef IB_LOAD_CHECKSUM_EN
  assign checksum_err     = err_q;
`endif

endmodule
